// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/ack fetch, one-word skid buffer, IF/ID register.
// Optional performance counters are enabled with `define IF_STAGE_PERF_EN.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction,
    output logic        valid
`ifdef IF_STAGE_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);
    localparam logic [31:0] BUBBLE = 32'hF000_0000;

    typedef enum logic [1:0] {FETCH, FULL, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redirect_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;
    logic        started;
    logic        ack;
    logic [31:0] target;
    logic [31:0] pc_next;

    // Request is a pure decode of registered state; held low for the cycle after reset.
    assign imem_req  = started && (state != FULL);
    assign imem_addr = pc;
    assign ack       = imem_ack && imem_req;
    assign target    = {branch_addr[31:2], 2'b00};
    assign pc_next   = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            redirect_pc <= 32'd0;
            skid_pc     <= 32'd0;
            skid_instr  <= BUBBLE;
            started     <= 1'b0;
            pc_out      <= 32'd0;
            instruction <= BUBBLE;
            valid       <= 1'b0;
        end else begin
            started <= 1'b1;
            if (branch_taken) begin
                pc_out      <= 32'd0;
                instruction <= BUBBLE;
                valid       <= 1'b0;
                skid_pc     <= 32'd0;
                skid_instr  <= BUBBLE;
                // An unanswered request must complete before the target can be issued.
                if (imem_req && !imem_ack) begin
                    redirect_pc <= target;
                    state       <= DRAIN;
                end else begin
                    pc    <= target;
                    state <= FETCH;
                end
            end else begin
                case (state)
                    DRAIN: begin
                        if (!freeze) begin
                            pc_out      <= 32'd0;
                            instruction <= BUBBLE;
                            valid       <= 1'b0;
                        end
                        if (ack) begin
                            pc    <= redirect_pc;
                            state <= FETCH;
                        end
                    end
                    FULL: begin
                        if (!freeze) begin
                            pc_out      <= skid_pc;
                            instruction <= skid_instr;
                            valid       <= 1'b1;
                            skid_pc     <= 32'd0;
                            skid_instr  <= BUBBLE;
                            state       <= FETCH;
                        end
                    end
                    default: begin
                        if (freeze) begin
                            if (ack) begin
                                skid_pc    <= pc_next;
                                skid_instr <= imem_rdata;
                                pc         <= pc_next;
                                state      <= FULL;
                            end
                        end else if (ack) begin
                            pc_out      <= pc_next;
                            instruction <= imem_rdata;
                            valid       <= 1'b1;
                            pc          <= pc_next;
                        end else begin
                            pc_out      <= pc_next;
                            instruction <= BUBBLE;
                            valid       <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

`ifdef IF_STAGE_PERF_EN
    logic load_valid;
    assign load_valid = !branch_taken &&
                        (((state == FETCH) && !freeze && ack) ||
                         ((state == FULL) && !freeze));

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (load_valid)
                fetch_count <= fetch_count + 32'd1;
            if (freeze || (state == DRAIN))
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage against a queue-based fetch model.
// Phases bias stimulus towards streaming, slow memory, freezes and branches.
module tb_if_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0040;
    localparam logic [31:0] BUBBLE   = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        rst, freeze, branch_taken, imem_ack;
    logic [31:0] branch_addr, imem_rdata;
    logic        imem_req, valid;
    logic [31:0] imem_addr, pc_out, instruction;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] fetch_count, stall_count;
`endif

    int total = 0;
    int bad   = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_out(pc_out), .instruction(instruction), .valid(valid)
`ifdef IF_STAGE_PERF_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: fetch pipeline as a PC, an optional held word (queue),
    // a pending-redirect flag and the IF/ID triple.
    logic [31:0] m_pc, m_target, m_id_pc, m_id_ins;
    bit          m_id_v, m_started, m_drain;
    logic [63:0] m_skid[$];
    int unsigned m_fetches, m_stalls;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h3C00_00C3;
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_target = 0; m_drain = 0; m_started = 0;
        m_skid.delete();
        m_id_pc = 0; m_id_ins = BUBBLE; m_id_v = 0;
        m_fetches = 0; m_stalls = 0;
    endtask

    task automatic model_step(input bit r, input bit frz, input bit br,
                              input logic [31:0] baddr, input bit ack_in,
                              input logic [31:0] rdata);
        bit req, ack;
        logic [63:0] w;
        if (r) begin
            model_reset();
            return;
        end
        req = m_started && (m_skid.size() == 0);
        ack = req && ack_in;
        if (frz || m_drain) m_stalls++;
        if (br) begin
            m_id_pc = 0; m_id_ins = BUBBLE; m_id_v = 0;
            m_skid.delete();
            if (req && !ack) begin
                m_drain = 1; m_target = baddr & 32'hFFFF_FFFC;
            end else begin
                m_drain = 0; m_pc = baddr & 32'hFFFF_FFFC;
            end
        end else if (m_drain) begin
            if (!frz) begin m_id_pc = 0; m_id_ins = BUBBLE; m_id_v = 0; end
            if (ack) begin m_drain = 0; m_pc = m_target; end
        end else if (m_skid.size() != 0) begin
            if (!frz) begin
                w = m_skid.pop_front();
                m_id_pc = w[63:32]; m_id_ins = w[31:0]; m_id_v = 1;
                m_fetches++;
            end
        end else if (frz) begin
            if (ack) begin
                m_skid.push_back({m_pc + 32'd4, rdata});
                m_pc = m_pc + 32'd4;
            end
        end else if (ack) begin
            m_id_pc = m_pc + 32'd4; m_id_ins = rdata; m_id_v = 1;
            m_pc = m_pc + 32'd4;
            m_fetches++;
        end else begin
            m_id_pc = m_pc + 32'd4; m_id_ins = BUBBLE; m_id_v = 0;
        end
        m_started = 1;
    endtask

    task automatic check_outputs();
        bit req_exp;
        req_exp = m_started && (m_skid.size() == 0);
        chk("imem_req", {31'd0, imem_req}, {31'd0, req_exp});
        if (req_exp) chk("imem_addr", imem_addr, m_pc);
        chk("pc_out", pc_out, m_id_pc);
        chk("instruction", instruction, m_id_ins);
        chk("valid", {31'd0, valid}, {31'd0, m_id_v});
`ifdef IF_STAGE_PERF_EN
        chk("fetch_count", fetch_count, m_fetches);
        chk("stall_count", stall_count, m_stalls);
`endif
    endtask

    // Per-phase percentages: ack, freeze, branch, reset.
    int p_ack, p_frz, p_br, p_rst;

    initial begin
        rst = 1; freeze = 0; branch_taken = 0; branch_addr = 0;
        imem_ack = 0; imem_rdata = 0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        for (int ph = 0; ph < 6; ph++) begin
            case (ph)
                0: begin p_ack = 100; p_frz = 0;  p_br = 0;  p_rst = 0; end
                1: begin p_ack = 35;  p_frz = 0;  p_br = 0;  p_rst = 0; end
                2: begin p_ack = 100; p_frz = 40; p_br = 0;  p_rst = 0; end
                3: begin p_ack = 40;  p_frz = 10; p_br = 15; p_rst = 0; end
                4: begin p_ack = 60;  p_frz = 30; p_br = 20; p_rst = 3; end
                default: begin p_ack = 50; p_frz = 25; p_br = 10; p_rst = 2; end
            endcase
            for (int cyc = 0; cyc < 500; cyc++) begin
                @(negedge clk);
                check_outputs();
                rst          = (cyc < 2 && ph != 0) ? 1'b0 : ($urandom_range(99) < p_rst);
                freeze       = ($urandom_range(99) < p_frz);
                branch_taken = ($urandom_range(99) < p_br);
                // Occasionally aim near the top of memory to exercise PC wrap.
                branch_addr  = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15)
                                                        : $urandom & 32'h0000_0FFF;
                imem_ack     = ($urandom_range(99) < p_ack);
                imem_rdata   = imem_req ? mem_word(imem_addr) : $urandom;
                model_step(rst, freeze, branch_taken, branch_addr, imem_ack, imem_rdata);
            end
        end
        @(negedge clk);
        check_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
